// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its consumers.
package fetch_stage_pkg;

  localparam int unsigned DATA_WID  = 32;
  localparam int unsigned IMEM_AWID = 14;

  localparam logic [DATA_WID-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [DATA_WID-1:0] RESET_PC = 32'h0000_0000;

  // IF/ID pipeline register payload, consumed directly by decode
  typedef struct packed {
    logic [DATA_WID-1:0] inst;
    logic [DATA_WID-1:0] pc;
    logic                valid;
  } if_id_t;

  // Force an address onto a word boundary
  function automatic logic [DATA_WID-1:0] word_align(input logic [DATA_WID-1:0] addr);
    return addr & ~DATA_WID'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush / hold / bubble control.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [DATA_WID-1:0] RST_PC      = 32'h0000_0000,
  parameter logic [DATA_WID-1:0] BUBBLE_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                hold,
  input  logic                bubble,
  input  logic [DATA_WID-1:0] inst_in,
  input  logic [DATA_WID-1:0] pc_in,
  output if_id_t              if_id
);

  if_id_t if_id_q;
  if_id_t if_id_d;

  // Next IF/ID contents: flush beats hold, hold beats bubble, else capture
  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d = '{inst: BUBBLE_INST, pc: pc_in, valid: 1'b0};
    end else if (hold) begin
      if_id_d = if_id_q;
    end else if (bubble) begin
      if_id_d = '{inst: BUBBLE_INST, pc: pc_in, valid: 1'b0};
    end else begin
      if_id_d = '{inst: inst_in, pc: pc_in, valid: 1'b1};
    end
  end

  // IF/ID register with synchronous reset to a bubble at the reset PC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_q <= '{inst: BUBBLE_INST, pc: RST_PC, valid: 1'b0};
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage: PC, BRAM addressing, IF/ID register, fetch counter.
module fetch_stage #(
  parameter logic [fetch_stage_pkg::DATA_WID-1:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
  parameter int unsigned                          IMEM_AWID = fetch_stage_pkg::IMEM_AWID,
  parameter logic [fetch_stage_pkg::DATA_WID-1:0] NOP_INST  = fetch_stage_pkg::NOP_INST
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 stall,
  input  logic                                 halt,
  input  logic                                 redirect,
  input  logic [fetch_stage_pkg::DATA_WID-1:0] redirect_pc,
  output logic [IMEM_AWID-1:0]                 imem_addr,
  output logic                                 imem_en,
  input  logic [fetch_stage_pkg::DATA_WID-1:0] imem_rdata,
  output logic [fetch_stage_pkg::DATA_WID-1:0] if_id_inst,
  output logic [fetch_stage_pkg::DATA_WID-1:0] if_id_pc,
  output logic                                 if_id_valid,
  output logic [fetch_stage_pkg::DATA_WID-1:0] fetch_cnt
);

  import fetch_stage_pkg::*;

  // pc_q is the PC whose instruction is currently on imem_rdata
  logic [DATA_WID-1:0] pc_q;
  logic [DATA_WID-1:0] pc_d;
  logic [DATA_WID-1:0] fetch_cnt_q;
  logic [DATA_WID-1:0] fetch_cnt_d;
  logic                capture_c;
  if_id_t              if_id;

  // Next PC: reset, then redirect, then hold on stall/halt, else sequential
  always_comb begin
    pc_d = pc_q + DATA_WID'(4);
    if (!rst_n) begin
      pc_d = RESET_PC;
    end else if (redirect) begin
      pc_d = word_align(redirect_pc);
    end else if (stall || halt) begin
      pc_d = pc_q;
    end
  end

  // BRAM is addressed with the upcoming PC so its data lines up with pc_q
  assign imem_addr = pc_d[IMEM_AWID+1:2];
  assign imem_en   = 1'b1;

  // A real instruction enters IF/ID only when nothing flushes, holds or bubbles
  assign capture_c = !redirect && !stall && !halt;

  // Fetch counter advances on every captured instruction
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (capture_c) begin
      fetch_cnt_d = fetch_cnt_q + DATA_WID'(1);
    end
  end

  // PC and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      fetch_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  if_id_reg #(
    .RST_PC      (RESET_PC),
    .BUBBLE_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect),
    .hold    (stall),
    .bubble  (halt),
    .inst_in (imem_rdata),
    .pc_in   (pc_q),
    .if_id   (if_id)
  );

  assign if_id_inst  = if_id.inst;
  assign if_id_pc    = if_id.pc;
  assign if_id_valid = if_id.valid;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a word-index BRAM model (mem[i] = i).
module tb_fetch_stage;

  localparam int unsigned AWID = 14;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk;
  logic            rst_n;
  logic            stall;
  logic            halt;
  logic            redirect;
  logic [31:0]     redirect_pc;
  logic [AWID-1:0] imem_addr;
  logic            imem_en;
  logic [31:0]     imem_rdata;
  logic [31:0]     if_id_inst;
  logic [31:0]     if_id_pc;
  logic            if_id_valid;
  logic [31:0]     fetch_cnt;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_AWID (AWID),
    .NOP_INST  (NOP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_rdata  (imem_rdata),
    .if_id_inst  (if_id_inst),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .fetch_cnt   (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous BRAM, one-cycle latency, each word holds its own index
  always @(posedge clk) imem_rdata <= 32'(imem_addr);

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected IF/ID result, compare after the edge
  task automatic step(input logic rst, input logic st, input logic hl, input logic rd,
                      input logic [31:0] rpc, input logic ev, input logic [31:0] ei,
                      input logic [31:0] ep, input logic [31:0] ec, input string tag);
    exp_t e;
    rst_n       = rst;
    stall       = st;
    halt        = hl;
    redirect    = rd;
    redirect_pc = rpc;
    sb_q.push_back('{valid: ev, inst: ei, pc: ep, cnt: ec, tag: tag});
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".valid"}, 32'(if_id_valid), 32'(e.valid));
      check({e.tag, ".inst"},  if_id_inst, e.inst);
      check({e.tag, ".pc"},    if_id_pc,   e.pc);
      check({e.tag, ".cnt"},   fetch_cnt,  e.cnt);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #1;
    check("reset_imem_addr", 32'(imem_addr), 32'h0);
    check("imem_en", 32'(imem_en), 32'h1);

    // reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'd0, "rst0");
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, NOP, 32'h0, 32'd0, "rst1");

    // free run
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd0, 32'h0, 32'd1, "run0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd1, 32'h4, 32'd2, "run1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd2, 32'h8, 32'd3, "run2");

    // stall two cycles
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'd2, 32'h8, 32'd3, "stall0");
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'd2, 32'h8, 32'd3, "stall1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd3, 32'hC, 32'd4, "post_stall0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd4, 32'h10, 32'd5, "post_stall1");

    // redirect to misaligned 0x103
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check("redir_imem_addr", 32'(imem_addr), 32'h40);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h103, 1'b0, NOP, 32'h14, 32'd5, "redir_flush");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 32'h100, 32'd6, "redir_target");

    // redirect and stall together
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 1'b0, NOP, 32'h104, 32'd6, "redir_stall_flush");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 32'h200, 32'd7, "redir_stall_target");

    // halt three cycles
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, NOP, 32'h204, 32'd7, "halt0");
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, NOP, 32'h204, 32'd7, "halt1");
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, NOP, 32'h204, 32'd7, "halt2");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h81, 32'h204, 32'd8, "post_halt0");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h82, 32'h208, 32'd9, "post_halt1");

    // reset during a redirect
    rst_n       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    #1;
    check("midrst_imem_addr", 32'(imem_addr), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, NOP, 32'h0, 32'd0, "midrst");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd0, 32'h0, 32'd1, "midrst_first");

    // PC wrap past the top of IMEM
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFF8, 1'b0, NOP, 32'h4, 32'd1, "wrap_flush");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3FFE, 32'hFFF8, 32'd2, "wrap0");
    check("wrap_imem_addr", 32'(imem_addr), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3FFF, 32'hFFFC, 32'd3, "wrap1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd0, 32'h10000, 32'd4, "wrap2");

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32 pipeline. It sits directly upstream of decode and feeds the Control decoder and register file.
- Owns the PC and drives the synchronous instruction memory, which has 1-cycle read latency.
- Owns the IF/ID pipeline register.
- Static predict-not-taken, with redirect from EX and stall from the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, first instruction address after reset
IMEM_AWID, 14, instruction-memory word-address width
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
stall  in  1  hold PC and IF/ID (load-use hazard from hazard unit)
halt  in  1  stop fetching (ecall/halt request); PC held, bubbles issued
redirect  in  1  branch taken / jal / jalr resolved in EX
redirect_pc  in  32  target address; bits[1:0] ignored
imem_addr  out  IMEM_AWID  word address to instruction BRAM
imem_en  out  1  BRAM read enable, constant 1
imem_rdata  in  32  BRAM data, valid 1 cycle after address
if_id_inst  out  32  instruction to decode
if_id_pc  out  32  PC of if_id_inst
if_id_valid  out  1  1 = real instruction, 0 = bubble
fetch_cnt  out  32  count of instructions captured into IF/ID

Behaviour:
Reset (rst_n=0 at posedge):
- pc_q <= RESET_PC.
- if_id_inst <= NOP_INST, if_id_pc <= RESET_PC, if_id_valid <= 0, fetch_cnt <= 0.
- While rst_n=0, imem_addr = RESET_PC[IMEM_AWID+1:2] and imem_en=1. On the first cycle after reset, imem_rdata therefore holds mem[RESET_PC].

pc_q definition: PC whose instruction is on imem_rdata in the current cycle.

next_pc, by priority:
1. redirect: {redirect_pc[31:2],2'b00}
2. stall or halt: pc_q
3. otherwise: pc_q+4, mod 2^32 with no trap
- imem_addr = next_pc[IMEM_AWID+1:2], combinational. Higher bits are truncated, so the address wraps within IMEM.
- pc_q <= next_pc every non-reset cycle.
- On stall/halt the BRAM re-reads the same word, so imem_rdata stays stable.

IF/ID update at posedge, by priority:
1. reset (above)
2. redirect: flush. inst <= NOP_INST, valid <= 0, pc <= pc_q. Wins over a simultaneous stall. The wrong-path word on imem_rdata is discarded.
3. stall: all IF/ID fields hold.
4. halt: bubble. inst <= NOP_INST, valid <= 0, pc <= pc_q.
5. normal: inst <= imem_rdata, pc <= pc_q, valid <= 1, fetch_cnt <= fetch_cnt+1 (wraps at 2^32).

Latency and penalty:
- Redirect asserted in cycle N: target instruction appears in IF/ID at end of cycle N+1.
- The two wrong-path slots (IF/ID and imem_rdata) are never marked valid.

Other rules:
- Halt deasserted: fetch resumes at the held pc_q with no lost or duplicated instruction.
- Reset asserted mid-stream overrides redirect, stall and halt in the same cycle.
- No combinational path from imem_rdata to imem_addr.
- redirect/stall/halt are treated as registered signals from downstream stages; no internal synchronisation.

Decomposition:
- Shared package holds DATA_WID (32), NOP_INST, RESET_PC, and a typedef if_id_t {inst, pc, valid}. The decode stage consumes this typedef directly.
- Natural sub-module: if_id_reg, holding the if_id_t register with flush/hold/bubble control inputs.
- PC logic and fetch_cnt stay in fetch_stage.

Test Plan:
- Reset, then free-run with mem[i]=i (word index):
  - first cycle after reset: IF/ID shows valid=0;
  - next three cycles: inst=0,1,2 with pc=0x0,0x4,0x8 and valid=1;
  - fetch_cnt=3.
- Stall for 2 cycles while IF/ID holds pc=0x8 → IF/ID stays {inst=2, pc=0x8}; then 0xC, 0x10 follow with none skipped or duplicated.
- Redirect to 0x103 while IF/ID pc=0x10:
  - next edge: valid=0;
  - the following edge: pc=0x100, inst=mem[0x40].
- Simultaneous redirect=1 and stall=1 → redirect wins: flush occurs and the target appears one cycle later.
- Halt for 3 cycles → three bubbles with valid=0 and fetch_cnt frozen; after release, the next valid pc is the one pending before halt.
- rst_n=0 mid-stream during an active redirect → next edge: pc_q=RESET_PC, valid=0, fetch_cnt=0; first post-reset fetch = mem[RESET_PC].
- PC wrap: with IMEM_AWID=14 at pc=0xFFFC → imem_addr wraps to 0; if_id_pc=0x10000.
